// File: rtl/npu_spi_cmd_decoder.sv
// npu_spi_cmd_decoder: groups SPI bytes into 4-byte command frames, validates
// them and queues legal commands for the tile controller (valid/ready drain).
// Malformed frames are dropped and reported via sticky flags and a drop counter.
module npu_spi_cmd_decoder #(
   parameter int FIFO_DEPTH = 4,
   parameter int TILE_MAX   = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_byte,
   input  logic       rx_valid,
   input  logic       frame_active,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic [7:0] cmd_code,
   output logic [2:0] cmd_tile_i,
   output logic [2:0] cmd_tile_j,
   output logic [2:0] cmd_op,
   output logic [7:0] cmd_data,
   output logic       err_frame,
   output logic       err_badcmd,
   output logic       err_overflow,
   output logic [7:0] drop_count,
   output logic       busy,
   input  logic       err_clear
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [2:0] TILE_LIM = 3'(TILE_MAX);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_CHECK,
      ST_WAIT_END,
      ST_DROP
   } state_t;

   state_t           state_reg, state_next;
   logic [2:0]       byte_cnt_reg;
   logic [7:0]       frame_byte_reg [4];
   logic             fa_prev_reg;
   logic             counted_reg;

   // FIFO storage and bookkeeping
   logic [7:0]       code_mem [FIFO_DEPTH];
   logic [2:0]       ti_mem   [FIFO_DEPTH];
   logic [2:0]       tj_mem   [FIFO_DEPTH];
   logic [2:0]       op_mem   [FIFO_DEPTH];
   logic [7:0]       data_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0] fifo_cnt_reg;

   logic             push, pop, fifo_full;
   logic             set_err_frame, set_err_badcmd, set_err_overflow, drop_evt;
   logic             frame_legal;
   logic [2:0]       f_tile_i, f_tile_j;

   assign f_tile_i  = frame_byte_reg[1][6:4];
   assign f_tile_j  = frame_byte_reg[1][2:0];

   // Opcode, tile range and reserved-bit checks on the assembled frame
   assign frame_legal = (frame_byte_reg[0] >= 8'h01) && (frame_byte_reg[0] <= 8'h04)
                     && (f_tile_i <= TILE_LIM) && (f_tile_j <= TILE_LIM)
                     && !frame_byte_reg[1][7] && !frame_byte_reg[1][3]
                     && (frame_byte_reg[2][7:3] == 5'd0);

   assign cmd_valid = (fifo_cnt_reg != '0);
   assign fifo_full = (fifo_cnt_reg == FIFO_FULL_CNT);
   assign pop       = cmd_valid && cmd_ready;
   assign busy      = (state_reg != ST_IDLE) || (fifo_cnt_reg != '0);

   // Head entry is presented straight from storage; zero while empty
   assign cmd_code   = cmd_valid ? code_mem[rd_ptr_reg] : 8'd0;
   assign cmd_tile_i = cmd_valid ? ti_mem[rd_ptr_reg]   : 3'd0;
   assign cmd_tile_j = cmd_valid ? tj_mem[rd_ptr_reg]   : 3'd0;
   assign cmd_op     = cmd_valid ? op_mem[rd_ptr_reg]   : 3'd0;
   assign cmd_data   = cmd_valid ? data_mem[rd_ptr_reg] : 8'd0;

   // Assembler state register, frame_active history and byte counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         fa_prev_reg  <= 1'b0;
         byte_cnt_reg <= 3'd0;
         counted_reg  <= 1'b0;
      end else begin
         state_reg   <= state_next;
         fa_prev_reg <= frame_active;
         if (state_reg == ST_IDLE) begin
            byte_cnt_reg <= 3'd0;
            counted_reg  <= 1'b0;
         end else begin
            if (state_reg == ST_COLLECT && rx_valid)
               byte_cnt_reg <= byte_cnt_reg + 3'd1;
            if (drop_evt)
               counted_reg <= 1'b1;
         end
      end
   end

   // Capture each frame byte into its slot selected by the byte counter
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_frame_byte
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               frame_byte_reg[gi] <= 8'd0;
            else if (state_reg == ST_COLLECT && rx_valid && byte_cnt_reg == 3'(gi))
               frame_byte_reg[gi] <= rx_byte;
         end
      end
   endgenerate

   // Next-state logic plus push and error event decode
   always_comb begin
      state_next       = state_reg;
      push             = 1'b0;
      set_err_frame    = 1'b0;
      set_err_badcmd   = 1'b0;
      set_err_overflow = 1'b0;
      drop_evt         = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (frame_active && !fa_prev_reg)
               state_next = ST_COLLECT;
         end
         ST_COLLECT: begin
            // the 4th byte completes the frame even if cs deasserts in the same cycle
            if (rx_valid && byte_cnt_reg == 3'd3) begin
               state_next = ST_CHECK;
            end else if (!frame_active) begin
               state_next    = ST_DROP;
               set_err_frame = 1'b1;
            end
         end
         ST_CHECK: begin
            if (!frame_legal) begin
               state_next     = ST_DROP;
               set_err_badcmd = 1'b1;
            end else if (fifo_full && !pop) begin
               // a simultaneous pop frees a slot, so full-with-pop still pushes
               state_next       = ST_DROP;
               set_err_overflow = 1'b1;
            end else begin
               push       = 1'b1;
               state_next = ST_WAIT_END;
            end
         end
         ST_WAIT_END: begin
            if (rx_valid && frame_active) begin
               set_err_frame = 1'b1;
               drop_evt      = !counted_reg;
            end
            if (!frame_active)
               state_next = ST_IDLE;
         end
         ST_DROP: begin
            drop_evt   = 1'b1;
            state_next = frame_active ? ST_WAIT_END : ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Command storage write; no reset needed since validity comes from the count
   always_ff @(posedge clk) begin
      if (push) begin
         code_mem[wr_ptr_reg] <= frame_byte_reg[0];
         ti_mem[wr_ptr_reg]   <= f_tile_i;
         tj_mem[wr_ptr_reg]   <= f_tile_j;
         op_mem[wr_ptr_reg]   <= frame_byte_reg[2][2:0];
         data_mem[wr_ptr_reg] <= frame_byte_reg[3];
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         fifo_cnt_reg <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         if (push && !pop)
            fifo_cnt_reg <= fifo_cnt_reg + CNT_W'(1);
         else if (pop && !push)
            fifo_cnt_reg <= fifo_cnt_reg - CNT_W'(1);
      end
   end

   // Sticky error flags; a new event beats a simultaneous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_frame    <= 1'b0;
         err_badcmd   <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         if (set_err_frame)
            err_frame <= 1'b1;
         else if (err_clear)
            err_frame <= 1'b0;
         if (set_err_badcmd)
            err_badcmd <= 1'b1;
         else if (err_clear)
            err_badcmd <= 1'b0;
         if (set_err_overflow)
            err_overflow <= 1'b1;
         else if (err_clear)
            err_overflow <= 1'b0;
      end
   end

   // Saturating drop counter; a drop coinciding with clear restarts at one
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_count <= 8'd0;
      end else if (drop_evt) begin
         if (err_clear)
            drop_count <= 8'd1;
         else if (drop_count != 8'hFF)
            drop_count <= drop_count + 8'd1;
      end else if (err_clear) begin
         drop_count <= 8'd0;
      end
   end

endmodule

// File: tb/tb_npu_spi_cmd_decoder.sv
module tb_npu_spi_cmd_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_active;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_code;
    logic [2:0] cmd_tile_i;
    logic [2:0] cmd_tile_j;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic       err_frame;
    logic       err_badcmd;
    logic       err_overflow;
    logic [7:0] drop_count;
    logic       busy;
    logic       err_clear;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    logic [7:0] exp_code [4];
    logic [7:0] exp_data [4];

    npu_spi_cmd_decoder #(.FIFO_DEPTH(4), .TILE_MAX(7)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .frame_active (frame_active),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_code     (cmd_code),
        .cmd_tile_i   (cmd_tile_i),
        .cmd_tile_j   (cmd_tile_j),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .err_frame    (err_frame),
        .err_badcmd   (err_badcmd),
        .err_overflow (err_overflow),
        .drop_count   (drop_count),
        .busy         (busy),
        .err_clear    (err_clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic frame_bytes(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3);
        frame_active = 1'b1;
        tick();
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
    endtask

    task automatic end_frame();
        frame_active = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst          = 1'b1;
        rx_byte      = 8'd0;
        rx_valid     = 1'b0;
        frame_active = 1'b0;
        cmd_ready    = 1'b0;
        err_clear    = 1'b0;
        tick();
        tick();

        check("rst_valid", cmd_valid, 1'b0);
        check("rst_code", cmd_code, 8'h00);
        check("rst_data", cmd_data, 8'h00);
        check("rst_errs", {err_frame, err_badcmd, err_overflow}, 3'b000);
        check("rst_drop", drop_count, 8'h00);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        tick();
        $display("txn reset released");

        cmd_ready = 1'b1;
        frame_bytes(8'h01, 8'h00, 8'h00, 8'hAA);
        check("t1_valid_n", cmd_valid, 1'b0);
        check("t1_busy_n", busy, 1'b1);
        frame_active = 1'b0;
        tick();
        check("t1_valid_n1", cmd_valid, 1'b1);
        check("t1_code", cmd_code, 8'h01);
        check("t1_tiles", {cmd_tile_i, cmd_tile_j}, 6'o00);
        check("t1_op", cmd_op, 3'd0);
        check("t1_data", cmd_data, 8'hAA);
        tick();
        check("t1_valid_n2", cmd_valid, 1'b0);
        check("t1_busy_end", busy, 1'b0);
        check("t1_errs", {err_frame, err_badcmd, err_overflow}, 3'b000);
        check("t1_drop", drop_count, 8'h00);
        $display("txn frame 01/00/00/AA done");

        cmd_ready = 1'b0;
        frame_bytes(8'h02, 8'h35, 8'h05, 8'h3C);
        end_frame();
        check("t2_valid", cmd_valid, 1'b1);
        check("t2_code", cmd_code, 8'h02);
        check("t2_tile_i", cmd_tile_i, 3'd3);
        check("t2_tile_j", cmd_tile_j, 3'd5);
        check("t2_op", cmd_op, 3'd5);
        check("t2_data", cmd_data, 8'h3C);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t2_hold_valid", cmd_valid, 1'b1);
            check("t2_hold_fields", {cmd_code, cmd_tile_i, cmd_tile_j, cmd_op, cmd_data},
                  {8'h02, 3'd3, 3'd5, 3'd5, 8'h3C});
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("t2_popped", cmd_valid, 1'b0);
        $display("txn frame 02/35/05/3C done");

        frame_bytes(8'h01, 8'h00, 8'h00, 8'h01);
        tick();
        send_byte(8'hEE);
        send_byte(8'hEE);
        end_frame();
        check("long_valid", cmd_valid, 1'b1);
        check("long_data", cmd_data, 8'h01);
        check("long_err_frame", err_frame, 1'b1);
        check("long_drop", drop_count, 8'd1);
        cmd_ready = 1'b1;
        err_clear = 1'b1;
        tick();
        cmd_ready = 1'b0;
        err_clear = 1'b0;
        check("long_cleared", {err_frame, drop_count, cmd_valid}, {1'b0, 8'd0, 1'b0});
        $display("txn long frame done");

        frame_active = 1'b1;
        tick();
        send_byte(8'h01);
        send_byte(8'h00);
        frame_active = 1'b0;
        tick();
        tick();
        check("short_err_frame", err_frame, 1'b1);
        check("short_drop", drop_count, 8'd1);
        check("short_valid", cmd_valid, 1'b0);
        check("short_busy", busy, 1'b0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("short_cleared", {err_frame, drop_count}, {1'b0, 8'd0});
        $display("txn short frame done");

        frame_bytes(8'h07, 8'h00, 8'h00, 8'h11);
        end_frame();
        check("bad_err_badcmd", err_badcmd, 1'b1);
        check("bad_err_frame", err_frame, 1'b0);
        check("bad_drop", drop_count, 8'd1);
        check("bad_valid", cmd_valid, 1'b0);
        frame_bytes(8'h03, 8'h12, 8'h01, 8'h77);
        end_frame();
        check("good_valid", cmd_valid, 1'b1);
        check("good_fields", {cmd_code, cmd_tile_i, cmd_tile_j, cmd_op, cmd_data},
              {8'h03, 3'd1, 3'd2, 3'd1, 8'h77});
        check("good_drop", drop_count, 8'd1);
        cmd_ready = 1'b1;
        err_clear = 1'b1;
        tick();
        cmd_ready = 1'b0;
        err_clear = 1'b0;
        check("good_cleared", {err_badcmd, drop_count, cmd_valid}, {1'b0, 8'd0, 1'b0});
        $display("txn bad opcode + good frame done");

        exp_code[0] = 8'h01; exp_data[0] = 8'h10;
        exp_code[1] = 8'h02; exp_data[1] = 8'h20;
        exp_code[2] = 8'h03; exp_data[2] = 8'h30;
        exp_code[3] = 8'h04; exp_data[3] = 8'h40;
        frame_bytes(8'h01, 8'h00, 8'h00, 8'h10); end_frame();
        frame_bytes(8'h02, 8'h11, 8'h01, 8'h20); end_frame();
        frame_bytes(8'h03, 8'h22, 8'h02, 8'h30); end_frame();
        frame_bytes(8'h04, 8'h33, 8'h03, 8'h40); end_frame();
        check("ovf_no_err_yet", err_overflow, 1'b0);
        frame_bytes(8'h01, 8'h44, 8'h04, 8'h50); end_frame();
        check("ovf_err", err_overflow, 1'b1);
        check("ovf_drop", drop_count, 8'd1);
        check("ovf_other_errs", {err_frame, err_badcmd}, 2'b00);
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", cmd_valid, 1'b1);
            check("drain_code", cmd_code, exp_code[i]);
            check("drain_data", cmd_data, exp_data[i]);
            $display("txn drain pop %0d code=%02h data=%02h", i, cmd_code, cmd_data);
            tick();
        end
        cmd_ready = 1'b0;
        check("drain_empty", cmd_valid, 1'b0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("clear_errs", {err_frame, err_badcmd, err_overflow}, 3'b000);
        check("clear_drop", drop_count, 8'd0);
        $display("txn overflow + drain + clear done");

        frame_bytes(8'h01, 8'h00, 8'h00, 8'h61); end_frame();
        frame_bytes(8'h02, 8'h00, 8'h00, 8'h62); end_frame();
        check("pre_rst_valid", cmd_valid, 1'b1);
        frame_active = 1'b1;
        tick();
        send_byte(8'h01);
        send_byte(8'h00);
        rst = 1'b1;
        #1;
        check("async_rst_valid", cmd_valid, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_code", cmd_code, 8'h00);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        frame_active = 1'b0;
        tick();
        frame_bytes(8'h04, 8'h77, 8'h07, 8'h5A);
        end_frame();
        check("post_rst_valid", cmd_valid, 1'b1);
        check("post_rst_fields", {cmd_code, cmd_tile_i, cmd_tile_j, cmd_op, cmd_data},
              {8'h04, 3'd7, 3'd7, 3'd7, 8'h5A});
        check("post_rst_errs", {err_frame, err_badcmd, err_overflow, drop_count},
              {3'b000, 8'd0});
        $display("txn reset mid-frame + recovery done");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/npu_spi_cmd_decoder.md
# npu_spi_cmd_decoder

Frame assembler and command queue between the SPI byte receiver and the NPU tile controller. It collects bytes already synchronised into the `clk` domain and groups them into fixed 4-byte command frames delimited by chip-select activity. It validates each frame and buffers accepted commands in a small FIFO, which the tile controller drains over a valid/ready handshake. Malformed frames are dropped and reported through sticky error flags and a drop counter.

## Interface
- `FIFO_DEPTH`, 4: command FIFO entries; power of two, 2–16.
- `TILE_MAX`, 7: highest legal `tile_i`/`tile_j` value; 0–7.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `rx_byte`  in  8  received SPI byte, MSB-first assembled upstream.
- `rx_valid`  in  1  one-cycle strobe, `rx_byte` valid.
- `frame_active`  in  1  synchronised inverse of `cs_n`; high during a frame.
- `cmd_valid`  out  1  FIFO head valid.
- `cmd_ready`  in  1  consumer accepts head.
- `cmd_code`  out  8  opcode byte of head command.
- `cmd_tile_i`  out  3  head tile row.
- `cmd_tile_j`  out  3  head tile column.
- `cmd_op`  out  3  head sub-operation.
- `cmd_data`  out  8  head data byte.
- `err_frame`  out  1  sticky: short or long frame seen.
- `err_badcmd`  out  1  sticky: illegal opcode or tile index seen.
- `err_overflow`  out  1  sticky: valid frame dropped, FIFO full.
- `drop_count`  out  8  frames dropped for any reason; saturates at 255.
- `busy`  out  1  frame in progress or FIFO non-empty.
- `err_clear`  in  1  clears the three sticky flags and `drop_count`.

## Operation
- Frame layout (byte order):
  - B0 = `cmd_code`.
  - B1 = {1'b0, tile_i[2:0], 1'b0, tile_j[2:0]}.
  - B2 = {5'b0, op[2:0]}.
  - B3 = data.
- Assembler FSM states:
  - IDLE: a rising edge of `frame_active` enters COLLECT with byte count 0.
  - COLLECT: each `rx_valid` stores the byte at index = count, then count++.
  - When count reaches 4, enter CHECK.
  - If `frame_active` falls with count < 4, enter DROP (short frame: `err_frame`).
  - CHECK: one cycle. The frame is legal iff `cmd_code` ∈ {0x01, 0x02, 0x03, 0x04}, `tile_i` ≤ `TILE_MAX`, `tile_j` ≤ `TILE_MAX`, and reserved bits are zero.
    - Illegal: DROP with `err_badcmd`.
    - Legal with FIFO full: DROP with `err_overflow`.
    - Otherwise push, then go to WAIT_END.
  - WAIT_END: any `rx_valid` while `frame_active` is high marks the frame long. Set `err_frame` and increment `drop_count`. The already-pushed command remains in the FIFO. A frame is counted once even if several extra bytes arrive. Leave to IDLE when `frame_active` falls.
  - DROP: increment `drop_count` (saturating), then go to WAIT_END, or to IDLE if `frame_active` is already low.
- `rx_valid` in IDLE with `frame_active` low is ignored.
- The FIFO pops when `cmd_valid && cmd_ready`. Outputs present the head entry combinationally from the storage array.
- Push and pop in the same cycle are both performed, including when the FIFO is full: pop frees a slot, so the push succeeds.
- Sticky flags and `drop_count` clear when `err_clear` is high. If an error event occurs in the same cycle as `err_clear`, the event wins: flag = 1, count = 1.
- `busy` = (state ≠ IDLE) || (FIFO count ≠ 0).

## Timing
- Reset values:
  - `cmd_valid` = 0, all `cmd_*` fields = 0.
  - `err_*` = 0, `drop_count` = 0, `busy` = 0.
  - FSM in IDLE, FIFO empty.
- Latency: the 4th `rx_valid` at edge N moves the FSM to CHECK. Push occurs at edge N+1, and `cmd_valid` is high after edge N+1.
- Back-to-back: a new `frame_active` rise is not recognised until the FSM returns to IDLE. `frame_active` low for at least 1 cycle between frames is required.
- `cmd_valid` stays high and `cmd_*` fields stay stable until a pop occurs.
- Reset mid-frame or mid-handshake discards partial frame and FIFO contents immediately (asynchronous).
- `frame_active` falling in the same cycle as the 4th `rx_valid`: the byte counts, and the frame is complete and legal-checked.

## Test plan
- Single frame 01 / 00 / 00 / AA with `cmd_ready` = 1:
  - `cmd_valid` pulses 1 cycle, two edges after the last byte.
  - Fields: code = 01, tile = (0, 0), op = 0, data = AA.
  - No errors.
- Frame 02 / 35 / 05 / 3C: tile_i = 3, tile_j = 5, op = 5, data = 3C. Hold `cmd_ready` = 0 for 10 cycles: fields stay stable, then pop on ready.
- Short frame (2 bytes, then `frame_active` falls): `err_frame` = 1, `drop_count` = 1, nothing pushed.
- Bad opcode 07 / 00 / 00 / 11: `err_badcmd` = 1, `drop_count` = 1. A following good frame is still accepted.
- With `FIFO_DEPTH` = 4 and `cmd_ready` = 0:
  - Send 5 legal frames: 4 queued, 5th dropped, `err_overflow` = 1.
  - Then drain: 4 pops in order.
  - Assert `err_clear`: all errors = 0, `drop_count` = 0.
- Assert `rst` mid-COLLECT with 2 commands queued: `cmd_valid` = 0 and `busy` = 0 immediately. The next full frame decodes normally.
